// File: rtl/apu_frame_seq.sv
// apu_frame_seq: APU frame counter sequencer.
// Generates quarter/half-frame clocks and the frame IRQ flag.
module apu_frame_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       wr_4017,
    input  logic [7:0] wdata,
    input  logic       rd_4015,
    output logic       qtrframe,
    output logic       halfframe,
    output logic       irq_flag,
    output logic       irq
);

    typedef enum logic {
        MODE_4STEP = 1'b0,
        MODE_5STEP = 1'b1
    } mode_e;

    localparam logic [15:0] STEP1 = 16'd7457;
    localparam logic [15:0] STEP2 = 16'd14913;
    localparam logic [15:0] STEP3 = 16'd22371;
    localparam logic [15:0] IRQ_A = 16'd29828;
    localparam logic [15:0] END4  = 16'd29829;
    localparam logic [15:0] END5  = 16'd37281;

    logic [15:0] cnt, cnt_n;
    logic        parity, parity_n;
    mode_e       mode, mode_n;
    mode_e       pend_mode, pend_n;
    logic        inhibit, inhibit_n;
    logic [2:0]  dly, dly_n;
    logic        wrap4, wrap4_n;
    logic        irq_n, qtr_n, half_n;
    logic        irq_set;
    logic        inh_eff;
    logic        expire;

    // a write in this cycle already governs inhibit and cancels expiry
    assign inh_eff = wr_4017 ? wdata[6] : inhibit;
    assign expire  = tick && !wr_4017 && (dly == 3'd1);
    assign irq     = irq_flag;

    // next-state: step events, mode-change delay and IRQ flag
    always_comb begin
        cnt_n     = cnt;
        parity_n  = parity;
        mode_n    = mode;
        pend_n    = pend_mode;
        inhibit_n = inhibit;
        dly_n     = dly;
        wrap4_n   = wrap4;
        irq_n     = irq_flag;
        qtr_n     = 1'b0;
        half_n    = 1'b0;
        irq_set   = 1'b0;
        if (tick) begin
            parity_n = ~parity;
            wrap4_n  = 1'b0;
            if (dly != 3'd0) dly_n = dly - 3'd1;
            if (expire) begin
                mode_n = pend_mode;
                cnt_n  = 16'd0;
                qtr_n  = (pend_mode == MODE_5STEP);
                half_n = (pend_mode == MODE_5STEP);
            end else begin
                cnt_n = cnt + 16'd1;
                if (cnt == STEP1 || cnt == STEP3) qtr_n = 1'b1;
                if (cnt == STEP2) begin
                    qtr_n  = 1'b1;
                    half_n = 1'b1;
                end
                if (mode == MODE_4STEP) begin
                    if (cnt == END4) begin
                        qtr_n   = 1'b1;
                        half_n  = 1'b1;
                        cnt_n   = 16'd0;
                        wrap4_n = 1'b1;
                    end
                    if (!inh_eff && (cnt == IRQ_A || cnt == END4 ||
                        (cnt == 16'd0 && wrap4)))
                        irq_set = 1'b1;
                end else if (cnt == END5) begin
                    qtr_n  = 1'b1;
                    half_n = 1'b1;
                    cnt_n  = 16'd0;
                end
            end
        end
        if (wr_4017) begin
            pend_n    = mode_e'(wdata[7]);
            inhibit_n = wdata[6];
            dly_n     = parity ? 3'd3 : 3'd4;
        end
        if (irq_set)
            irq_n = 1'b1;
        else if (rd_4015 || (wr_4017 && wdata[6]))
            irq_n = 1'b0;
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 16'd0;
            parity    <= 1'b0;
            mode      <= MODE_4STEP;
            pend_mode <= MODE_4STEP;
            inhibit   <= 1'b0;
            dly       <= 3'd0;
            wrap4     <= 1'b0;
            irq_flag  <= 1'b0;
            qtrframe  <= 1'b0;
            halfframe <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            parity    <= parity_n;
            mode      <= mode_n;
            pend_mode <= pend_n;
            inhibit   <= inhibit_n;
            dly       <= dly_n;
            wrap4     <= wrap4_n;
            irq_flag  <= irq_n;
            qtrframe  <= qtr_n;
            halfframe <= half_n;
        end
    end

endmodule

// File: tb/tb_apu_frame_seq.sv
// tb_apu_frame_seq: self-checking bench for apu_frame_seq.
// Positional frame model plus literal event-time checks.
module tb_apu_frame_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       wr_4017;
    logic [7:0] wdata;
    logic       rd_4015;
    logic       qtrframe;
    logic       halfframe;
    logic       irq_flag;
    logic       irq;

    always #5 clk = ~clk;

    apu_frame_seq dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .wr_4017   (wr_4017),
        .wdata     (wdata),
        .rd_4015   (rd_4015),
        .qtrframe  (qtrframe),
        .halfframe (halfframe),
        .irq_flag  (irq_flag),
        .irq       (irq)
    );

    int checks = 0;
    int passed = 0;

    // model: absolute tick index, sequence origin, scheduled mode switch
    int m_t     = 0;
    int m_org   = 0;
    int m_apply = -1;
    bit m_mode  = 0;
    bit m_pend  = 0;
    bit m_inh   = 0;
    bit m_flag  = 0;

    int q_log[$];
    int h_log[$];
    int f_log[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input bit r, input bit t, input bit w,
                       input logic [7:0] d, input bit rd);
        bit eq, eh, set, e_inh;
        int tb0, per, el, c, dd;
        rst = r; tick = t; wr_4017 = w; wdata = d; rd_4015 = rd;
        tb0 = m_t; eq = 0; eh = 0; set = 0;
        if (r) begin
            m_t = 0; m_org = 0; m_apply = -1;
            m_mode = 0; m_pend = 0; m_inh = 0; m_flag = 0;
        end else begin
            e_inh = w ? d[6] : m_inh;
            if (t) begin
                if (m_apply == tb0 && !w) begin
                    m_mode  = m_pend;
                    m_org   = tb0 + 1;
                    eq      = m_pend;
                    eh      = m_pend;
                    m_apply = -1;
                end else begin
                    per = m_mode ? 37282 : 29830;
                    el  = tb0 - m_org;
                    c   = el % per;
                    eq  = (c == 7457 || c == 14913 || c == 22371 ||
                           c == per - 1);
                    eh  = (c == 14913 || c == per - 1);
                    if (!m_mode && !e_inh &&
                        (c == 29828 || c == 29829 ||
                         (c == 0 && el >= per)))
                        set = 1;
                end
                m_t++;
            end
            if (w) begin
                dd      = (tb0 % 2 == 1) ? 3 : 4;
                m_pend  = d[7];
                m_inh   = d[6];
                m_apply = t ? tb0 + dd : tb0 + dd - 1;
            end
            if (set) m_flag = 1;
            else if (rd || (w && d[6])) m_flag = 0;
        end
        @(posedge clk);
        #1;
        chk("outs", {28'd0, qtrframe, halfframe, irq_flag, irq},
            {28'd0, eq, eh, m_flag, m_flag});
        if (!r && t) begin
            if (qtrframe) q_log.push_back(tb0);
            if (halfframe) h_log.push_back(tb0);
            if (irq_flag) f_log.push_back(tb0);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(0, 1, 0, 8'h00, 0);
    endtask

    task automatic clr_logs();
        q_log.delete();
        h_log.delete();
        f_log.delete();
    endtask

    int base;
    int nq;

    initial begin
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        chk("rst_outs", {29'd0, qtrframe, halfframe, irq_flag}, 32'd0);

        // run to cnt==20000, then reset with a colliding write
        ticks(20000);
        chk("pre_q_cnt", q_log.size(), 2);
        chk("pre_q0", q_log[0], 7457);
        chk("pre_q1", q_log[1], 14913);
        clr_logs();
        cyc(1, 1, 1, 8'hC0, 0);
        chk("midrst_outs", {29'd0, qtrframe, halfframe, irq_flag}, 32'd0);

        // full 4-step period from reset
        ticks(29828);
        cyc(0, 1, 0, 8'h00, 0);
        chk("irq_at_29828", irq_flag, 1);
        cyc(0, 0, 0, 8'h00, 1);
        chk("rd_clear", irq_flag, 0);
        cyc(0, 1, 0, 8'h00, 1);
        chk("rd_vs_set", irq_flag, 1);
        chk("end4_pulse", {30'd0, qtrframe, halfframe}, 32'd3);
        cyc(0, 0, 1, 8'h40, 0);
        chk("wr40_clear", irq_flag, 0);
        ticks(4);
        chk("inh_thru_wrap", irq_flag, 0);
        chk("q_cnt", q_log.size(), 4);
        chk("q0", q_log[0], 7457);
        chk("q1", q_log[1], 14913);
        chk("q2", q_log[2], 22371);
        chk("q3", q_log[3], 29829);
        chk("h_cnt", h_log.size(), 2);
        chk("h0", h_log[0], 14913);
        chk("h1", h_log[1], 29829);
        chk("irq_first", f_log[0], 29828);

        // superseded 5-step write never applies
        nq = q_log.size();
        cyc(0, 0, 1, 8'h80, 0);
        ticks(2);
        cyc(0, 0, 1, 8'h00, 0);
        ticks(10);
        chk("no_5step_pulse", q_log.size() - nq, 0);

        // 5-step switch from even parity, then one full period
        if (m_t % 2 == 1) ticks(1);
        clr_logs();
        cyc(0, 0, 1, 8'h80, 0);
        base = m_t;
        ticks(37300);
        chk("5s_delay", q_log[0] - base + 1, 4);
        chk("5s_h_cnt", h_log.size(), 3);
        chk("5s_imm_half", h_log[0] - base + 1, 4);
        chk("5s_half2", h_log[1] - (base + 4), 14913);
        chk("5s_wrap", h_log[2] - (base + 4), 37281);
        chk("5s_no_irq", f_log.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/apu_frame_seq.md
APU_FRAME_SEQ -- requirements
Module: apu_frame_seq

Interface
REQ-001 SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 SHALL have no parameters; all step counts are fixed constants in CPU cycles.
REQ-003 SHALL have port `clk  in  1`: system clock.
REQ-004 SHALL have port `rst  in  1`: synchronous active-high reset.
REQ-005 SHALL have port `tick  in  1`: CPU-cycle enable, one clk cycle wide; all counting advances only on tick.
REQ-006 SHALL have port `wr_4017  in  1`: one-cycle write strobe for the frame-counter register.
REQ-007 SHALL have port `wdata  in  8`: write data; bit7 = mode (0 = 4-step, 1 = 5-step); bit6 = IRQ inhibit.
REQ-008 SHALL have port `rd_4015  in  1`: one-cycle status-read strobe that acknowledges the frame IRQ.
REQ-009 SHALL have port `qtrframe  out  1`: one-clk pulse that clocks envelopes and linear counters.
REQ-010 SHALL have port `halfframe  out  1`: one-clk pulse that clocks length counters and sweeps.
REQ-011 SHALL have port `irq_flag  out  1`: frame-interrupt flag (status bit 6).
REQ-012 SHALL have port `irq  out  1`: equal to irq_flag.

Function
REQ-013 SHALL keep a 16-bit step counter cnt that increments by 1 on every tick.
REQ-014 SHALL keep a parity bit that toggles on every tick.
REQ-015 SHALL register qtrframe and halfframe so each is high exactly one clk cycle, namely the cycle after the tick that meets its condition, and low otherwise.
REQ-016 In both modes, SHALL pulse qtrframe on the tick where cnt==7457 or cnt==22371.
REQ-017 In both modes, SHALL pulse qtrframe and halfframe together on the tick where cnt==14913.
REQ-018 In 4-step mode, SHALL pulse qtrframe and halfframe on the tick where cnt==29829, and that tick SHALL load cnt with 0 (period 29830).
REQ-019 In 4-step mode with inhibit==0, SHALL set irq_flag on ticks where cnt==29828 or cnt==29829, and on the cnt==0 tick immediately following a 4-step wrap.
REQ-020 In 5-step mode, SHALL pulse qtrframe and halfframe on the tick where cnt==37281, and that tick SHALL load cnt with 0 (period 37282).
REQ-021 In 5-step mode, SHALL never set irq_flag.
REQ-022 On wr_4017, SHALL latch inhibit immediately.
REQ-023 On wr_4017 with wdata[6]==1, SHALL clear irq_flag on the next clk.
REQ-024 On wr_4017, SHALL store wdata[7] as pending_mode and arm a delay of 3 ticks if parity==1 at the write, else 4 ticks.
REQ-025 When the armed delay expires (on that tick), SHALL set mode to pending_mode and load cnt with 0; no step event SHALL be evaluated on that tick.
REQ-026 If the new mode is 5-step, the expiry tick SHALL also pulse qtrframe and halfframe.
REQ-027 A wr_4017 while a delay is armed SHALL restart the delay with the new data; the earlier write SHALL never apply.
REQ-028 rd_4015 SHALL clear irq_flag.
REQ-029 If rd_4015 coincides with a set condition, set SHALL win and irq_flag SHALL be 1.
REQ-030 wr_4017 with inhibit=1 coinciding with a set condition SHALL leave irq_flag 0.
REQ-031 wr_4017 and rd_4015 are never asserted together; behaviour in that case is unspecified.
REQ-032 Without tick, no counter, parity, delay or flag update SHALL occur, except the clears of REQ-023 and REQ-028.
REQ-033 SHALL wrap cnt only as stated in REQ-018 and REQ-020; cnt never exceeds 37281.

Reset
REQ-034 On rst, SHALL set cnt=0, parity=0, mode=4-step, inhibit=0, pending delay disarmed, irq_flag=0, qtrframe=0 and halfframe=0.
REQ-035 Reset SHALL override any pending write or clear in that cycle.
REQ-036 Reset mid-period SHALL restart the sequence so that the first qtrframe occurs on the tick where cnt==7457 counted from reset.

Verification
REQ-037 Reset, then tick every clk -> qtr pulses at ticks 7457, 14913, 22371 and 29829; half pulses at 14913 and 29829; irq_flag=1 from tick 29828; cnt==0 after tick 29829.
REQ-038 Write 0x80 with parity=0 -> exactly 4 ticks later, qtr and half pulse together and cnt=0; next half pulse 14913 ticks later; irq_flag stays 0 for a full 37282-tick period.
REQ-039 irq_flag=1, then rd_4015 -> flag 0 on next clk; rd_4015 on the tick where cnt==29829 -> flag remains 1.
REQ-040 irq_flag=1, then write 0x40 -> flag 0 on next clk and stays 0 through the next 4-step wrap.
REQ-041 Write 0x80, then write 0x00 two ticks later -> no 5-step immediate pulses occur; mode stays 4-step; delay restarts from the second write.
REQ-042 Assert rst at cnt==20000 -> all outputs 0; next qtr pulse exactly 7457 ticks after reset release.
